// File: rtl/freq_sweep.sv
// Linear frequency sweep generator feeding a DDFS tuning word (fcontrol).
// Steps f_start..f_stop by f_step, holding each word dwell+1 cycles; optional auto-repeat.
module freq_sweep #(
    parameter int FW = 23,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          repeat_mode,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    output logic [FW-1:0] fcontrol,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, DWELL, HOLD_LAST} state_t;

    state_t        state, state_nxt;
    logic [FW-1:0] fc_nxt, start_q, stop_q, step_q;
    logic [DW-1:0] dwell_q, cnt, cnt_nxt;
    logic          repeat_q;
    logic          accept, reject, done_nxt, err_nxt;
    logic [FW:0]   sum;
    logic          sum_clamp;

    // stop wins over start, so a simultaneous start is neither accepted nor rejected
    assign accept    = (state == IDLE) && start && !stop && (f_step != '0) && (f_start <= f_stop);
    assign reject    = (state == IDLE) && start && !stop && ((f_step == '0) || (f_start > f_stop));
    assign sum       = {1'b0, fcontrol} + {1'b0, step_q};
    assign sum_clamp = (sum >= {1'b0, stop_q});
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (f_start == f_stop) ? HOLD_LAST : DWELL;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if ((cnt == '0) && sum_clamp) begin
                    state_nxt = HOLD_LAST;
                end
            end
            HOLD_LAST: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    if (repeat_q) begin
                        state_nxt = (start_q == stop_q) ? HOLD_LAST : DWELL;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fc_nxt   = fcontrol;
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        err_nxt  = reject;
        case (state)
            IDLE: begin
                if (accept) begin
                    fc_nxt  = f_start;
                    cnt_nxt = dwell;
                end
            end
            DWELL: begin
                if (!stop) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        fc_nxt  = sum_clamp ? stop_q : sum[FW-1:0];
                        cnt_nxt = dwell_q;
                    end
                end
            end
            HOLD_LAST: begin
                if (!stop) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (repeat_q) begin
                        fc_nxt  = start_q;
                        cnt_nxt = dwell_q;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                fc_nxt = fcontrol;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcontrol <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            repeat_q <= 1'b0;
        end else begin
            fcontrol <= fc_nxt;
            cnt      <= cnt_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            if (accept) begin
                start_q  <= f_start;
                stop_q   <= f_stop;
                step_q   <= f_step;
                dwell_q  <= dwell;
                repeat_q <= repeat_mode;
            end
        end
    end

endmodule

// File: doc/freq_sweep.md
FREQ_SWEEP -- requirements
Module: freq_sweep

Interface
REQ-001 SHALL have parameter FW, default 23: width of all frequency words, matching the DDFS fcontrol input.
REQ-002 SHALL have parameter DW, default 16: width of the dwell count.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a sweep.
REQ-006 SHALL have port stop, input, 1: one-cycle request to abort a sweep.
REQ-007 SHALL have port repeat, input, 1: 0 = single sweep, 1 = restart at f_start after each sweep end.
REQ-008 SHALL have port f_start, input, FW: first tuning word, unsigned.
REQ-009 SHALL have port f_stop, input, FW: last tuning word, unsigned.
REQ-010 SHALL have port f_step, input, FW: increment per step, unsigned.
REQ-011 SHALL have port dwell, input, DW: each word is held for dwell+1 cycles.
REQ-012 SHALL have port fcontrol, output, FW: registered tuning word, driven directly into the DDFS fcontrol input.
REQ-013 SHALL have port busy, output, 1: high while a sweep is active.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a single sweep completes.
REQ-015 SHALL have port err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-016 SHALL implement the states IDLE, DWELL and HOLD_LAST; busy SHALL be 1 exactly in DWELL and HOLD_LAST.
REQ-017 SHALL, in IDLE on start, when f_step != 0 and f_start <= f_stop:
  - latch f_start, f_stop, f_step, dwell and repeat into internal registers;
  - load fcontrol <= f_start and the dwell counter <= dwell;
  - enter DWELL on the next edge.
REQ-018 SHALL ignore later changes to configuration inputs until the next accepted start.
REQ-019 SHALL, in IDLE on start with f_step == 0 or f_start > f_stop: pulse err for one cycle, remain in IDLE, and leave fcontrol unchanged.
REQ-020 SHALL decrement the dwell counter by 1 each cycle in DWELL and HOLD_LAST while it is nonzero.
REQ-021 SHALL, in DWELL when the counter == 0:
  - compute sum = fcontrol + f_step in FW+1 bits;
  - if sum >= f_stop, load fcontrol <= f_stop (clamp) and enter HOLD_LAST;
  - otherwise load fcontrol <= sum[FW-1:0] and stay in DWELL;
  - in both cases reload the counter <= dwell.
REQ-022 SHALL never let fcontrol exceed the latched f_stop or wrap modulo 2^FW.
REQ-023 SHALL, in HOLD_LAST when the counter == 0:
  - if repeat = 1: load fcontrol <= f_start, reload the counter, enter DWELL, no done;
  - if repeat = 0: enter IDLE, pulse done for one cycle, and keep fcontrol at f_stop.
REQ-024 SHALL enter HOLD_LAST directly from the accepted start when f_start == f_stop.
REQ-025 SHALL ignore start while busy = 1.
REQ-026 SHALL, on stop in DWELL or HOLD_LAST, enter IDLE on the next edge, hold fcontrol at its current value, and not pulse done.
REQ-027 SHALL treat stop in IDLE as a no-op.
REQ-028 SHALL give stop priority over start when both are asserted in the same cycle, so that no sweep begins.
REQ-029 SHALL have a latency of one cycle from an accepted start to fcontrol = f_start and busy = 1.
REQ-030 SHALL keep every word value on fcontrol for exactly dwell+1 cycles, including f_start and the clamped f_stop.
REQ-031 SHALL make done and err mutually exclusive, each lasting exactly one cycle.

Reset
REQ-032 SHALL, on rst_n = 0, immediately and asynchronously set: state IDLE, fcontrol 0, busy 0, done 0, err 0, dwell counter 0, latched configuration 0.
REQ-033 SHALL, on rst_n asserted mid-sweep, abort the sweep with no done pulse, and SHALL make the first start after release behave as from power-up.

Verification
REQ-034 SHALL cover single sweep: f_start=100, f_stop=130, f_step=10, dwell=2, repeat=0 -> fcontrol 100,110,120,130, each for 3 cycles; then done pulses once and busy drops, with fcontrol held at 130.
REQ-035 SHALL cover clamp: f_start=0, f_stop=25, f_step=10, dwell=0 -> fcontrol 0,10,20,25, one cycle each; then done pulses.
REQ-036 SHALL cover overflow: f_start=0x7FFFF0, f_stop=0x7FFFFF, f_step=0x20, dwell=0 -> fcontrol 0x7FFFF0, then 0x7FFFFF, with no wrap to a small value.
REQ-037 SHALL cover repeat with stop: REQ-034 settings with repeat=1 -> after 130 held 3 cycles, fcontrol returns to 100 with no done; a stop during the second 110 -> IDLE next edge, fcontrol stays 110, no done.
REQ-038 SHALL cover rejects and priority: f_step=0 -> err pulse, busy stays 0; f_start=50, f_stop=40 -> err pulse; start and stop in the same cycle -> busy stays 0.
REQ-039 SHALL cover reset mid-sweep: rst_n low during DWELL -> fcontrol and busy go to 0 before the next clk edge; start after release -> fcontrol = f_start one cycle later.
